// File: rtl/seg7.sv
`default_nettype none
// ============================================================================
// Module      : seg7
// Description : Registered seven-segment decoder for one HEX digit.
//               Decodes a 4-bit value into an active-low segment pattern.
//               The pattern is registered, so the digit is glitch-free and
//               appears exactly one clock after the value is sampled.
// Ports       : clk   - system clock, rising edge
//               reset - synchronous, active-high; blanks the digit
//               bcd   - value to display, 0..15
//               leds  - segments {g,f,e,d,c,b,a}, active-low (0 = lit)
// Options     : SEG7_HEX_EN - when defined, codes 10..15 show A,b,C,d,E,F;
//               otherwise they show blank.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd,
  output logic [6:0] leds
);

  localparam logic [6:0] C_BLANK = 7'b1111111;

  logic [6:0] w_seg;
  logic [6:0] r_leds;

  // Full decode: the default keeps every code covered, so no latch and no X.
  always_comb begin
    w_seg = C_BLANK;
    case (bcd)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
`ifdef SEG7_HEX_EN
      4'd10:   w_seg = 7'b0001000;
      4'd11:   w_seg = 7'b0000011;
      4'd12:   w_seg = 7'b1000110;
      4'd13:   w_seg = 7'b0100001;
      4'd14:   w_seg = 7'b0000110;
      4'd15:   w_seg = 7'b0001110;
`else
      // Codes 10..15 fall through to blank in the decimal-only build.
`endif
      default: w_seg = C_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds <= C_BLANK;
    end else begin
      r_leds <= w_seg;
    end
  end

  assign leds = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_seg7.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7
// Description : Directed self-checking bench for seg7. Expected patterns are
//               hand-written constants; upper-code expectations follow the
//               SEG7_HEX_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7;

  logic       clk;
  logic       reset;
  logic [3:0] bcd;
  logic [6:0] leds;

  int checks;
  int errors;

  logic [6:0] exp_tab [16];

  seg7 dut (
    .clk   (clk),
    .reset (reset),
    .bcd   (bcd),
    .leds  (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] expected);
    checks++;
    assert (leds === expected)
    else begin
      errors++;
      $error("FAIL %s: leds=%b expected=%b", tag, leds, expected);
    end
  endtask

  // Apply inputs, take one rising edge, then sample 1 ns after it.
  task automatic step(input logic rst_v, input logic [3:0] bcd_v,
                      input logic [6:0] expected, input string tag);
    reset = rst_v;
    bcd   = bcd_v;
    @(posedge clk);
    #1;
    check(tag, expected);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    exp_tab[0]  = 7'b1000000;
    exp_tab[1]  = 7'b1111001;
    exp_tab[2]  = 7'b0100100;
    exp_tab[3]  = 7'b0110000;
    exp_tab[4]  = 7'b0011001;
    exp_tab[5]  = 7'b0010010;
    exp_tab[6]  = 7'b0000010;
    exp_tab[7]  = 7'b1111000;
    exp_tab[8]  = 7'b0000000;
    exp_tab[9]  = 7'b0010000;
`ifdef SEG7_HEX_EN
    exp_tab[10] = 7'b0001000;
    exp_tab[11] = 7'b0000011;
    exp_tab[12] = 7'b1000110;
    exp_tab[13] = 7'b0100001;
    exp_tab[14] = 7'b0000110;
    exp_tab[15] = 7'b0001110;
`else
    for (int i = 10; i < 16; i++) exp_tab[i] = 7'b1111111;
`endif

    // Reset held two cycles with bcd=8: stays blank.
    step(1'b1, 4'd8, 7'b1111111, "reset_edge0");
    step(1'b1, 4'd8, 7'b1111111, "reset_edge1");
    // First edge with reset low decodes the sampled 8.
    step(1'b0, 4'd8, 7'b0000000, "reset_release");

    // Digit sweep, one per cycle.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'(i), exp_tab[i], $sformatf("digit_%0d", i));
    end

    // Upper codes 10..15.
    for (int i = 10; i < 16; i++) begin
      step(1'b0, 4'(i), exp_tab[i], $sformatf("upper_%0d", i));
    end

    // Mid-run reset with bcd=5 held.
    step(1'b0, 4'd5, 7'b0010010, "pre_reset_5");
    step(1'b1, 4'd5, 7'b1111111, "midrun_reset");
    step(1'b0, 4'd5, 7'b0010010, "post_reset_5");

    // A change between edges must not show until the next edge.
    step(1'b0, 4'd2, 7'b0100100, "hold_2");
    bcd = 4'd6;
    #2;
    check("between_edges", 7'b0100100);
    @(posedge clk);
    #1;
    check("after_edge_6", 7'b0000010);

    // Fast toggling 1/7 for 10 cycles, nothing dropped.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step(1'b0, 4'd1, 7'b1111001, $sformatf("toggle_%0d", i));
      else            step(1'b0, 4'd7, 7'b1111000, $sformatf("toggle_%0d", i));
    end

    // Final reset blanks the display again.
    step(1'b1, 4'd0, 7'b1111111, "final_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
